// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: issues one ADC command per sample period and
// converts the 12-bit unsigned result to a 16-bit signed audio sample.
// Optional macro ADC_OVERSAMPLE_EN: four conversions per tick, averaged.
module adc_sample_sequencer #(
  parameter int CLK_DIV  = 1042,
  parameter int CHANNEL  = 1,
  parameter int TIMEOUT  = 255,
  parameter int MIDSCALE = 2048
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        enable,
  output logic        adc_command_valid,
  output logic [4:0]  adc_command_channel,
  output logic        adc_command_startofpacket,
  output logic        adc_command_endofpacket,
  input  logic        adc_command_ready,
  input  logic        adc_response_valid,
  input  logic [4:0]  adc_response_channel,
  input  logic [11:0] adc_response_data,
  input  logic        adc_response_startofpacket,
  input  logic        adc_response_endofpacket,
  output logic [15:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  output logic        timeout_err,
  input  logic        flags_clear
);

  localparam logic [4:0]  CH       = 5'(CHANNEL);
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [15:0] MID      = 16'(MIDSCALE);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_OUT} state_t;

  state_t      r_state;
  logic [15:0] r_div_cnt;
  logic [7:0]  r_to_cnt;
  logic        r_cmd_valid;
  logic [15:0] r_sample_data;
  logic        r_sample_valid;
  logic        r_overrun;
  logic        r_timeout_err;

  logic w_tick;
  logic w_rsp_hit;
  logic w_ovr_set;
  logic w_to_set;
  logic w_unused;

  // Packet framing on the response side carries no information here.
  assign w_unused = adc_response_startofpacket ^ adc_response_endofpacket;

`ifdef ADC_OVERSAMPLE_EN
  logic [13:0] r_acc;
  logic [1:0]  r_nsub;
  logic [13:0] w_sum;
  logic [11:0] w_avg;
  assign w_sum = r_acc + {2'b00, adc_response_data};
  assign w_avg = w_sum[13:2];
`endif

  // Centre the code on zero and scale 12 bits up to the 16-bit range.
  function automatic logic [15:0] to_sample(input logic [11:0] code);
    logic [15:0] diff;
    diff = {4'b0000, code} - MID;
    return {diff[11:0], 4'b0000};
  endfunction

  assign w_tick    = enable && (r_div_cnt == DIV_LAST);
  assign w_rsp_hit = adc_response_valid && (adc_response_channel == CH);
  assign w_ovr_set = w_tick && (r_state != S_IDLE);
  assign w_to_set  = (r_state == S_WAIT) && !w_rsp_hit && (r_to_cnt == TO_LAST);

  // Sample-period divider; parked at zero while disabled.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)                r_div_cnt <= '0;
    else if (!enable)               r_div_cnt <= '0;
    else if (r_div_cnt == DIV_LAST) r_div_cnt <= '0;
    else                            r_div_cnt <= r_div_cnt + 16'd1;
  end

  // Transaction FSM: command handshake, response wait with timeout, output hold.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state        <= S_IDLE;
      r_cmd_valid    <= 1'b0;
      r_to_cnt       <= '0;
      r_sample_data  <= '0;
      r_sample_valid <= 1'b0;
`ifdef ADC_OVERSAMPLE_EN
      r_acc          <= '0;
      r_nsub         <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state     <= S_CMD;
            r_cmd_valid <= 1'b1;
          end
        end
        S_CMD: begin
          if (adc_command_ready) begin
            r_state     <= S_WAIT;
            r_cmd_valid <= 1'b0;
            r_to_cnt    <= '0;
          end
        end
        S_WAIT: begin
          if (w_rsp_hit) begin
`ifdef ADC_OVERSAMPLE_EN
            if (r_nsub == 2'd3) begin
              r_sample_data  <= to_sample(w_avg);
              r_sample_valid <= 1'b1;
              r_state        <= S_OUT;
              r_acc          <= '0;
              r_nsub         <= '0;
            end else begin
              r_acc       <= w_sum;
              r_nsub      <= r_nsub + 2'd1;
              r_state     <= S_CMD;
              r_cmd_valid <= 1'b1;
            end
`else
            r_sample_data  <= to_sample(adc_response_data);
            r_sample_valid <= 1'b1;
            r_state        <= S_OUT;
`endif
          end else if (r_to_cnt == TO_LAST) begin
            r_state <= S_IDLE;
`ifdef ADC_OVERSAMPLE_EN
            r_acc   <= '0;
            r_nsub  <= '0;
`endif
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
        end
        S_OUT: begin
          if (sample_ready) begin
            r_state        <= S_IDLE;
            r_sample_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky error flags; a set event outranks a simultaneous clear.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_ovr_set)        r_overrun <= 1'b1;
      else if (flags_clear) r_overrun <= 1'b0;
      if (w_to_set)         r_timeout_err <= 1'b1;
      else if (flags_clear) r_timeout_err <= 1'b0;
    end
  end

  assign adc_command_valid         = r_cmd_valid;
  assign adc_command_channel       = r_cmd_valid ? CH : 5'd0;
  assign adc_command_startofpacket = r_cmd_valid;
  assign adc_command_endofpacket   = r_cmd_valid;
  assign sample_data               = r_sample_data;
  assign sample_valid              = r_sample_valid;
  assign overrun                   = r_overrun;
  assign timeout_err               = r_timeout_err;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Bench for adc_sample_sequencer: directed and random ADC transactions
// compared against an arithmetic reference for conversion and timing.
module tb_adc_sample_sequencer;

  localparam int CLK_DIV  = 16;
  localparam int CHANNEL  = 1;
  localparam int TIMEOUT  = 8;
  localparam int MIDSCALE = 2048;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        enable = 1'b0;
  logic        adc_command_valid;
  logic [4:0]  adc_command_channel;
  logic        adc_command_startofpacket;
  logic        adc_command_endofpacket;
  logic        adc_command_ready = 1'b0;
  logic        adc_response_valid = 1'b0;
  logic [4:0]  adc_response_channel = 5'd0;
  logic [11:0] adc_response_data = 12'd0;
  logic        adc_response_startofpacket = 1'b0;
  logic        adc_response_endofpacket = 1'b0;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        overrun;
  logic        timeout_err;
  logic        flags_clear = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int last_cmd = -1;

  adc_sample_sequencer #(
    .CLK_DIV(CLK_DIV), .CHANNEL(CHANNEL), .TIMEOUT(TIMEOUT), .MIDSCALE(MIDSCALE)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .enable(enable),
    .adc_command_valid(adc_command_valid),
    .adc_command_channel(adc_command_channel),
    .adc_command_startofpacket(adc_command_startofpacket),
    .adc_command_endofpacket(adc_command_endofpacket),
    .adc_command_ready(adc_command_ready),
    .adc_response_valid(adc_response_valid),
    .adc_response_channel(adc_response_channel),
    .adc_response_data(adc_response_data),
    .adc_response_startofpacket(adc_response_startofpacket),
    .adc_response_endofpacket(adc_response_endofpacket),
    .sample_data(sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun(overrun),
    .timeout_err(timeout_err),
    .flags_clear(flags_clear)
  );

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  // Reference conversion: plain integer arithmetic, truncated to 16 bits.
  function automatic logic [15:0] ref_sample(input int code);
    return 16'((code - MIDSCALE) * 16);
  endfunction

  task automatic wait_cmd(input bit chk_period, output int waited);
    waited = 0;
    while (!adc_command_valid && waited < 64) begin
      step();
      waited++;
    end
    chk("cmd_arrives", 32'(adc_command_valid), 32'd1);
    if (chk_period && last_cmd >= 0)
      chk("cmd_period", 32'(cyc - last_cmd), 32'(CLK_DIV));
    last_cmd = cyc;
  endtask

  // Serve one transaction starting in the command phase.
  task automatic serve(input logic [11:0] d, input int rd, input int respd,
                       input int srd, input logic exp_ovr, input logic exp_to);
    int bad;
    int nocmd;
    logic [15:0] exp;
    exp = ref_sample(int'(d));
    bad = 0;
    for (int i = 0; i < rd; i++) begin
      if (!(adc_command_valid && adc_command_channel == 5'(CHANNEL) &&
            adc_command_startofpacket && adc_command_endofpacket)) bad++;
      step();
    end
    chk("cmd_stable", 32'(bad), 32'd0);
    chk("cmd_channel", 32'(adc_command_channel), 32'(CHANNEL));
    chk("cmd_sop_eop", 32'({adc_command_startofpacket, adc_command_endofpacket}), 32'd3);
    adc_command_ready = 1'b1;
    step();
    adc_command_ready = 1'b0;
    chk("cmd_drop", 32'(adc_command_valid), 32'd0);
    for (int i = 0; i < respd; i++) step();
    chk("no_early_sample", 32'(sample_valid), 32'd0);
    adc_response_valid   = 1'b1;
    adc_response_channel = 5'(CHANNEL);
    adc_response_data    = d;
    step();
    adc_response_valid = 1'b0;
    chk("sample_valid", 32'(sample_valid), 32'd1);
    chk("sample_data", 32'(sample_data), 32'(exp));
    bad = 0;
    nocmd = 0;
    for (int i = 0; i < srd; i++) begin
      step();
      if (!sample_valid || sample_data !== exp) bad++;
      if (adc_command_valid) nocmd++;
    end
    chk("out_hold", 32'(bad), 32'd0);
    chk("no_cmd_in_out", 32'(nocmd), 32'd0);
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    chk("valid_drop", 32'(sample_valid), 32'd0);
    chk("overrun", 32'(overrun), 32'(exp_ovr));
    chk("timeout_err", 32'(timeout_err), 32'(exp_to));
  endtask

  initial begin
    int w;
    int n;
    int sv_bad;
    logic [11:0] d;

    // Reset state
    step();
    step();
    chk("rst_cmd_valid", 32'(adc_command_valid), 32'd0);
    chk("rst_channel", 32'(adc_command_channel), 32'd0);
    chk("rst_sop_eop", 32'({adc_command_startofpacket, adc_command_endofpacket}), 32'd0);
    chk("rst_sample", 32'({sample_valid, sample_data}), 32'd0);
    chk("rst_flags", 32'({overrun, timeout_err}), 32'd0);

    // First command one full divider period after release
    reset_reset = 1'b0;
    enable = 1'b1;
    wait_cmd(1'b0, w);
    chk("first_cmd_delay", 32'(w), 32'(CLK_DIV));
    serve(12'hC00, 0, 2, 0, 1'b0, 1'b0);

    // Conversion end points and midscale
    wait_cmd(1'b1, w);
    serve(12'h000, 1, 0, 1, 1'b0, 1'b0);
    wait_cmd(1'b1, w);
    serve(12'hFFF, 0, 1, 2, 1'b0, 1'b0);
    wait_cmd(1'b1, w);
    serve(12'h800, 2, 0, 0, 1'b0, 1'b0);

    // Command stalled five cycles by the core
    wait_cmd(1'b1, w);
    serve(12'h123, 5, 0, 0, 1'b0, 1'b0);

    // Random data and handshake delays
    for (int k = 0; k < 8; k++) begin
      d = 12'($urandom_range(0, 4095));
      wait_cmd(1'b1, w);
      serve(d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    // Downstream stall across several ticks
    wait_cmd(1'b1, w);
    serve(12'($urandom_range(0, 4095)), 0, 1, 40, 1'b1, 1'b0);

    // Stray channel response, then timeout
    wait_cmd(1'b0, w);
    adc_command_ready = 1'b1;
    step();
    adc_command_ready = 1'b0;
    sv_bad = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      adc_response_valid   = (i == 2);
      adc_response_channel = 5'd3;
      adc_response_data    = 12'h5A5;
      step();
      if (sample_valid) sv_bad++;
    end
    adc_response_valid = 1'b0;
    chk("to_not_early", 32'(timeout_err), 32'd0);
    step();
    chk("to_set", 32'(timeout_err), 32'd1);
    chk("to_no_sample", 32'(sv_bad + int'(sample_valid)), 32'd0);

    // Next tick still issues a command; flags stay sticky until cleared
    wait_cmd(1'b0, w);
    chk("flags_sticky", 32'({overrun, timeout_err}), 32'd3);
    flags_clear = 1'b1;
    step();
    flags_clear = 1'b0;
    chk("flags_cleared", 32'({overrun, timeout_err}), 32'd0);
    serve(12'($urandom_range(0, 4095)), 0, 0, 0, 1'b0, 1'b0);

    // Re-create an overrun, then reset mid-command
    wait_cmd(1'b1, w);
    serve(12'($urandom_range(1, 4095)), 0, 0, 20, 1'b1, 1'b0);
    wait_cmd(1'b0, w);
    step();
    #2;
    reset_reset = 1'b1;
    #1;
    chk("arst_cmd_valid", 32'(adc_command_valid), 32'd0);
    chk("arst_channel", 32'(adc_command_channel), 32'd0);
    chk("arst_sample", 32'({sample_valid, sample_data}), 32'd0);
    chk("arst_flags", 32'({overrun, timeout_err}), 32'd0);
    step();
    step();
    reset_reset = 1'b0;

    // Late response after reset is ignored; first command after CLK_DIV
    adc_response_valid   = 1'b1;
    adc_response_channel = 5'(CHANNEL);
    adc_response_data    = 12'hABC;
    step();
    adc_response_valid = 1'b0;
    n = 1;
    chk("late_rsp_ignored", 32'(sample_valid), 32'd0);
    while (!adc_command_valid && n < 64) begin
      step();
      n++;
    end
    chk("cmd_after_reset", 32'(n), 32'(CLK_DIV));

    // Dropping enable lets the in-flight transaction finish, then stops ticks
    enable = 1'b0;
    serve(12'h7FF, 1, 1, 1, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 3 * CLK_DIV; i++) begin
      step();
      if (adc_command_valid) n++;
    end
    chk("no_cmd_disabled", 32'(n), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_sample_sequencer.md
Name: adc_sample_sequencer

Overview:
- Drives the ADC core's Avalon-ST command port at a fixed audio sample rate and captures its response stream.
- Converts each 12-bit unsigned conversion to a 16-bit signed audio sample.
- Presents samples on a valid/ready stream to the effects pipeline, with sticky overrun and timeout flags.
- Sits between the ADC core and the first effects stage.

Parameters:
- CLK_DIV, 1042: clk_clk cycles per sample period (50 MHz / 1042 ≈ 48 kHz); legal range 16..65535.
- CHANNEL, 1: 5-bit ADC channel to sample.
- TIMEOUT, 255: max cycles to wait for a response after command accept; legal range 1..255.
- MIDSCALE, 2048: unsigned code subtracted to centre the signal.

Ports:
- clk_clk  in  1  single clock, shared with ADC core clock domain
- reset_reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = run sample timer
- adc_command_valid  out  1  command request
- adc_command_channel  out  5  always CHANNEL
- adc_command_startofpacket  out  1  always 1 while valid
- adc_command_endofpacket  out  1  always 1 while valid
- adc_command_ready  in  1  core accepts command
- adc_response_valid  in  1  conversion result valid
- adc_response_channel  in  5  result channel
- adc_response_data  in  12  unsigned result
- adc_response_startofpacket  in  1  ignored
- adc_response_endofpacket  in  1  ignored
- sample_data  out  16  signed sample
- sample_valid  out  1  sample available
- sample_ready  in  1  downstream accepts
- overrun  out  1  sticky: a tick was dropped
- timeout_err  out  1  sticky: response never arrived
- flags_clear  in  1  clears overrun and timeout_err

Behaviour:
- Reset (async assert, sync release): all outputs 0; divider 0; FSM IDLE; captured sample 0. Reset mid-transaction drops adc_command_valid immediately; any late response is ignored.
- Divider:
  - enable=1: counts 0..CLK_DIV-1 and wraps.
  - tick = 1 for one cycle when count == CLK_DIV-1.
  - enable=0: divider held at 0, no ticks.
  - An in-flight transaction still completes after enable drops.
- FSM states: IDLE, CMD, WAIT, OUT.
  - IDLE: tick -> CMD.
  - CMD: adc_command_valid=1 with channel/sop/eop stable. Held until the cycle with adc_command_ready=1, then -> WAIT (valid low next cycle). Valid never drops before acceptance.
  - WAIT: timeout counter starts at 0 on entry and increments each cycle.
    - adc_response_valid=1 with adc_response_channel==CHANNEL: capture data, -> OUT.
    - Response with another channel: ignored.
    - Counter reaches TIMEOUT: timeout_err<=1, -> IDLE, no sample produced.
  - OUT: sample_valid=1 and sample_data stable until sample_ready=1 is seen; then -> IDLE, valid low next cycle. sample_ready=1 in the first OUT cycle is a 1-cycle handshake.
- Conversion: sample_data = (data - MIDSCALE) << 4, signed 16-bit. 0 -> -32768 (0x8000); 2048 -> 0; 4095 -> 32752 (0x7FF0). No saturation is needed.
- Latency: tick to adc_command_valid is 1 cycle. Response capture to sample_valid is 1 cycle.
- Overrun: a tick arriving while FSM != IDLE is dropped and overrun<=1. This includes a tick in the same cycle as OUT->IDLE, since the FSM is not IDLE in that cycle.
- Sticky flags: flags_clear=1 clears both flags. If a set event coincides with flags_clear, the set wins.
- One transaction outstanding at most; no buffering beyond the single output register.

Optional Feature:
- Macro ADC_OVERSAMPLE_EN, defined: each tick runs 4 back-to-back CMD/WAIT transactions.
  - Responses are accumulated in a 14-bit sum; averaged = sum >> 2 is converted as above.
  - OUT is entered only after the 4th response.
  - A timeout on any of the 4 aborts the set, sets timeout_err, returns to IDLE and discards the sum.
  - CLK_DIV must exceed 4x the ADC conversion time.
- Macro not defined: single transaction per tick; no accumulator logic is present.

Test Plan:
- CLK_DIV=16, enable=1, core model ready=1 with response data 0xC00 after 3 cycles -> one command per 16 cycles; sample_data=0x4000, sample_valid one cycle after response.
- Response data 0x000, then 0xFFF, then 0x800 -> sample_data 0x8000, 0x7FF0, 0x0000.
- Hold ready=0 for 5 cycles in CMD -> command_valid, channel and sop/eop stable all 5 cycles; single acceptance.
- sample_ready=0 for 40 cycles with CLK_DIV=16 -> sample_data held, overrun=1, no new command until handshake; flags_clear -> overrun=0.
- Response with channel 3 only (CHANNEL=1), TIMEOUT=8 -> stray response ignored; timeout_err=1 after 8 WAIT cycles; no sample_valid; next tick issues a new command.
- Assert reset_reset during WAIT -> all outputs 0 asynchronously; after release, the first command appears after CLK_DIV cycles. With ADC_OVERSAMPLE_EN, responses 0x800, 0x801, 0x802, 0x803 -> sample_data 0x0010.
